// File: rtl/ekg_pkg.sv
// Shared types and defaults for the ECG front-end blocks.
package ekg_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 12;
    localparam int unsigned THRESH_DEF     = 2000;
    localparam int unsigned HYST_DEF       = 100;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        WAIT_LOW,
        ARMED,
        TRACK,
        REFRACT
    } rpk_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/r_peak_detector.sv
// R-peak detector: threshold with hysteresis, refractory window, peak and
// R-R interval reporting. One evt_out pulse per beat.
module r_peak_detector
    import ekg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 12,
    parameter int unsigned REFRACT_SAMPLES = 50,
    parameter int unsigned INTERVAL_WIDTH  = 16
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [DATA_WIDTH-1:0]     sample_in,
    input  logic                      sample_valid_in,
    input  logic [DATA_WIDTH-1:0]     thresh_in,
    input  logic [DATA_WIDTH-1:0]     hyst_in,
    output logic                      evt_out,
    output logic [DATA_WIDTH-1:0]     peak_out,
    output logic [INTERVAL_WIDTH-1:0] interval_out
);

    localparam int unsigned RW = $clog2(REFRACT_SAMPLES + 1);

    rpk_state_t                state;
    logic [DATA_WIDTH-1:0]     lo;
    logic [DATA_WIDTH-1:0]     run_max;
    logic [INTERVAL_WIDTH-1:0] interval_count;
    logic [INTERVAL_WIDTH-1:0] interval_next;
    logic [RW-1:0]             refract_count;
    logic                      fall;
    logic                      refract_done;

    always_comb begin
        lo            = (hyst_in > thresh_in) ? '0 : thresh_in - hyst_in;
        fall          = sample_valid_in && (state == TRACK) && (sample_in < lo);
        interval_next = (&interval_count) ? interval_count : interval_count + 1'b1;
        refract_done  = (refract_count == RW'(REFRACT_SAMPLES - 1));
    end

    // Interval counts every valid sample; the event sample restarts it at 0.
    sat_counter #(.WIDTH(INTERVAL_WIDTH)) u_interval (
        .clk   (clk_in),
        .rst_n (rst_in),
        .en    (sample_valid_in),
        .clr   (fall),
        .count (interval_count)
    );

    sat_counter #(.WIDTH(RW)) u_refract (
        .clk   (clk_in),
        .rst_n (rst_in),
        .en    (sample_valid_in && (state == REFRACT)),
        .clr   (fall),
        .count (refract_count)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state        <= WAIT_LOW;
            evt_out      <= 1'b0;
            peak_out     <= '0;
            interval_out <= '0;
            run_max      <= '0;
        end else begin
            evt_out <= 1'b0;
            if (sample_valid_in) begin
                case (state)
                    WAIT_LOW: if (sample_in < lo) state <= ARMED;
                    ARMED: begin
                        if (sample_in >= thresh_in) begin
                            state   <= TRACK;
                            run_max <= sample_in;
                        end
                    end
                    TRACK: begin
                        if (sample_in > run_max) run_max <= sample_in;
                        if (fall) begin
                            evt_out      <= 1'b1;
                            peak_out     <= run_max;
                            interval_out <= interval_next;
                            state        <= REFRACT;
                        end
                    end
                    REFRACT: if (refract_done) state <= WAIT_LOW;
                    default: state <= WAIT_LOW;
                endcase
            end
        end
    end

endmodule

// File: doc/r_peak_detector.md
Name: r_peak_detector

Overview:
- Upstream stage of the beat-event counter. Takes the ECG ADC sample stream and detects R-peaks using a threshold with hysteresis and a refractory window.
- Emits one single-cycle `evt_out` pulse per beat; this drives the counter's `evt_in`.
- Also reports the peak amplitude of each beat and the R-R interval in samples.

Parameters:
- DATA_WIDTH, 12, sample width (unsigned ADC code).
- REFRACT_SAMPLES, 50, valid samples ignored after each event. Legal range ≥1.
- INTERVAL_WIDTH, 16, width of the R-R interval counter (saturating).

Ports:
- clk_in  input  1  system clock; everything is on its rising edge.
- rst_in  input  1  synchronous, active-low reset (0 = reset).
- sample_in  input  DATA_WIDTH  ECG sample.
- sample_valid_in  input  1  `sample_in` is valid this cycle.
- thresh_in  input  DATA_WIDTH  upper (trigger) threshold.
- hyst_in  input  DATA_WIDTH  hysteresis; low level = `thresh_in - hyst_in`, saturating at 0.
- evt_out  output  1  one-cycle beat pulse.
- peak_out  output  DATA_WIDTH  maximum sample of the last beat.
- interval_out  output  INTERVAL_WIDTH  valid samples between the last two events.

Behaviour:
- Reset (rst_in == 0 at a clock edge):
  - `evt_out`, `peak_out`, `interval_out`, running max, interval count and refractory count all go to 0.
  - State goes to WAIT_LOW.
  - Reset has priority over everything, including mid-TRACK or mid-REFRACT.
- Qualifying: state, counters and running max change only on cycles with `sample_valid_in == 1`. Invalid cycles hold all state, and `sample_in` is ignored on them.
- Comparisons are unsigned. `thresh_in` and `hyst_in` are sampled on each valid cycle (no latching). Low level `lo = (hyst_in > thresh_in) ? 0 : thresh_in - hyst_in`.
- Interval count:
  - Increments on every valid sample, saturating at 2^INTERVAL_WIDTH-1.
  - On an event sample, `interval_out <= count + 1` (saturated), and count <= 0.
  - `interval_out` therefore includes the event sample. The first event after reset counts from reset.
- FSM (transitions on valid samples only):
  - WAIT_LOW: `sample < lo` → ARMED. This prevents a false trigger when reset happens while the signal is high.
  - ARMED: `sample >= thresh_in` → TRACK, with running max <= sample.
  - TRACK:
    - Running max <= max(running max, sample).
    - If `sample < lo`: `peak_out <= running max` (not including the current sample), `interval_out` is updated, `evt_out` <= 1 on the next cycle, refractory count <= 0, and state → REFRACT.
    - Samples between `lo` and `thresh_in` stay in TRACK (hysteresis).
  - REFRACT: refractory count increments. When it reaches REFRACT_SAMPLES-1 on a valid sample → WAIT_LOW. Threshold crossings inside the window are ignored.
- Latency: `evt_out` is high for exactly one cycle, the cycle after the clock edge that consumed the falling-crossing sample. `peak_out` and `interval_out` update on that same edge and hold until the next event.
- `evt_out` is never high on two consecutive cycles.

Decomposition:
- Shared package `ekg_pkg`:
  - `sample_t` (logic [DATA_WIDTH-1:0]).
  - `rpk_state_t` enum {WAIT_LOW, ARMED, TRACK, REFRACT}.
  - Default-threshold constants.
- One sub-module, `sat_counter`: a parameterised width, enable/clear, saturating up-counter. It is used for both the interval counter and the refractory counter.
- FSM and peak tracking stay in the top.

Test Plan (defaults unless stated; thresh=2000, hyst=100, so lo=1900):
- Basic beat: reset, then valid samples 1000, 2100, 2500, 2300, 1800 → `evt_out` pulses once, one cycle after the 1800 sample; `peak_out`=2500; `interval_out`=5.
- High at reset: samples 2500, 2500, 2500 → no event. Then 1000, 2200, 1500 → one event, `peak_out`=2200.
- Hysteresis: 1000, 2100, 1950, 2050, 1850 → exactly one event, `peak_out`=2100. The 1950 sample must not end TRACK.
- Refractory (REFRACT_SAMPLES=4):
  - After a beat, the sequence 2500, 1000, 2500, 1000 inside the window → no event.
  - Then 1000, 2300, 1000 → event, with `interval_out` counting all valid samples since the prior event.
- Valid gaps: beat stream with `sample_valid_in`=0 cycles carrying 4095/0 garbage → response identical to the gap-free stream; `interval_out` excludes invalid cycles.
- Reset mid-TRACK and saturation:
  - Drive rst_in=0 during TRACK → all outputs 0 next cycle, no `evt_out`, state WAIT_LOW.
  - With INTERVAL_WIDTH=4, 30 valid low samples then a beat → `interval_out`=15.
